// File: rtl/hazard_control.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control
//  Description : Pipeline hazard unit. It detects load-use hazards between the
//                decode (FD) and execute (DX) latches and sequences a
//                multi-cycle multiply/divide unit. While an operation is in
//                flight, dependent or conflicting instructions are held back.
//                When the result arrives, the unit takes one writeback cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_control #(
   parameter int MD_TIMEOUT = 40
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] FD_ir,
   input  logic [31:0] DX_ir,
   input  logic        md_result_ready,
   output logic        stall_pc,
   output logic        stall_fd,
   output logic        flush_dx,
   output logic        md_start,
   output logic        md_busy,
   output logic [4:0]  md_rd,
   output logic        md_wb_en,
   output logic        md_timeout,
   output logic [15:0] stall_count
);

   // ------------------------------------------------------------------------
   // Opcode and ALU-op encodings
   // ------------------------------------------------------------------------
   localparam logic [4:0] c_op_rtype = 5'b00000;
   localparam logic [4:0] c_op_bne   = 5'b00010;
   localparam logic [4:0] c_op_jr    = 5'b00100;
   localparam logic [4:0] c_op_addi  = 5'b00101;
   localparam logic [4:0] c_op_blt   = 5'b00110;
   localparam logic [4:0] c_op_sw    = 5'b00111;
   localparam logic [4:0] c_op_lw    = 5'b01000;
   localparam logic [4:0] c_op_bex   = 5'b10110;
   localparam logic [4:0] c_alu_mul  = 5'b00110;
   localparam logic [4:0] c_alu_div  = 5'b00111;
   localparam logic [4:0] c_reg_exc  = 5'd30;

   // The run counter only needs to reach MD_TIMEOUT-1. That value is the
   // last cycle spent waiting before the operation is abandoned.
   localparam int                 c_cnt_w    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MD_RUN = 2'd1,
      ST_MD_WB  = 2'd2
   } state_t;

   state_t              r_state;
   logic [4:0]          r_md_rd;
   logic [c_cnt_w-1:0]  r_run_cnt;
   logic                r_md_busy;
   logic                r_md_wb_en;
   logic                r_md_timeout;
   logic [15:0]         r_stall_count;

   // ------------------------------------------------------------------------
   // Field decode
   // ------------------------------------------------------------------------
   logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
   logic [4:0] w_dx_op, w_dx_rd, w_dx_aluop;

   assign w_fd_op    = FD_ir[31:27];
   assign w_fd_rd    = FD_ir[26:22];
   assign w_fd_rs    = FD_ir[21:17];
   assign w_fd_rt    = FD_ir[16:12];
   assign w_dx_op    = DX_ir[31:27];
   assign w_dx_rd    = DX_ir[26:22];
   assign w_dx_aluop = DX_ir[6:2];

   // These bits (immediates, shamt, FD aluop) play no part in hazard detection.
   logic w_unused_bits;
   assign w_unused_bits = &{1'b0, FD_ir[11:0], DX_ir[21:7], DX_ir[1:0]};

   // ------------------------------------------------------------------------
   // Source registers read by the FD instruction. An unused slot is r0,
   // which can never match because no hazard is reported on r0.
   // ------------------------------------------------------------------------
   logic [4:0] w_fd_src_a;
   logic [4:0] w_fd_src_b;
   logic       w_fd_writes_rd;

   // Map the FD opcode to the registers it reads and whether it writes rd
   always_comb begin
      w_fd_src_a     = 5'd0;
      w_fd_src_b     = 5'd0;
      w_fd_writes_rd = 1'b0;
      case (w_fd_op)
         c_op_rtype: begin
            w_fd_src_a     = w_fd_rs;
            w_fd_src_b     = w_fd_rt;
            w_fd_writes_rd = 1'b1;
         end
         c_op_addi, c_op_lw: begin
            w_fd_src_a     = w_fd_rs;
            w_fd_writes_rd = 1'b1;
         end
         c_op_sw, c_op_bne, c_op_blt: begin
            w_fd_src_a = w_fd_rs;
            w_fd_src_b = w_fd_rd;
         end
         c_op_jr: begin
            w_fd_src_a = w_fd_rd;
         end
         c_op_bex: begin
            w_fd_src_a = c_reg_exc;
         end
         default: begin
            w_fd_src_a = 5'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Hazard terms
   // ------------------------------------------------------------------------
   logic w_dx_is_lw;
   logic w_dx_is_md;
   logic w_load_use;
   logic w_md_raw;
   logic w_md_waw;
   logic w_md_hazard;
   logic w_stall;

   assign w_dx_is_lw = (w_dx_op == c_op_lw);
   assign w_dx_is_md = (w_dx_op == c_op_rtype) &&
                       ((w_dx_aluop == c_alu_mul) || (w_dx_aluop == c_alu_div));

   assign w_load_use = w_dx_is_lw && (w_dx_rd != 5'd0) &&
                       ((w_fd_src_a == w_dx_rd) || (w_fd_src_b == w_dx_rd));

   assign w_md_raw = (r_md_rd != 5'd0) &&
                     ((w_fd_src_a == r_md_rd) || (w_fd_src_b == r_md_rd));
   assign w_md_waw = (r_md_rd != 5'd0) && w_fd_writes_rd && (w_fd_rd == r_md_rd);

   // A second mul/div reaching DX during a run is held off, not started.
   assign w_md_hazard = (r_state == ST_MD_RUN) && (w_md_raw || w_md_waw || w_dx_is_md);

   // The writeback cycle takes the register-file port, so it always bubbles.
   assign w_stall = reset_n && (w_load_use || w_md_hazard || (r_state == ST_MD_WB));

   assign stall_pc    = w_stall;
   assign stall_fd    = w_stall;
   assign flush_dx    = w_stall;
   assign md_start    = reset_n && (r_state == ST_IDLE) && w_dx_is_md;
   assign md_busy     = r_md_busy;
   assign md_rd       = r_md_rd;
   assign md_wb_en    = r_md_wb_en;
   assign md_timeout  = r_md_timeout;
   assign stall_count = r_stall_count;

   // ------------------------------------------------------------------------
   // Multiply/divide sequencer: start, wait for ready or timeout, writeback
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_md_rd      <= 5'd0;
         r_run_cnt    <= '0;
         r_md_busy    <= 1'b0;
         r_md_wb_en   <= 1'b0;
         r_md_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_dx_is_md) begin
                  r_md_rd   <= w_dx_rd;
                  r_run_cnt <= '0;
                  r_md_busy <= 1'b1;
                  r_state   <= ST_MD_RUN;
               end
            end
            ST_MD_RUN: begin
               // A ready arriving on the final allowed cycle still wins.
               if (md_result_ready) begin
                  r_run_cnt  <= r_run_cnt + 1'b1;
                  r_md_wb_en <= 1'b1;
                  r_state    <= ST_MD_WB;
               end else if (r_run_cnt == c_cnt_last) begin
                  r_md_timeout <= 1'b1;
                  r_md_rd      <= 5'd0;
                  r_md_busy    <= 1'b0;
                  r_state      <= ST_IDLE;
               end else begin
                  r_run_cnt <= r_run_cnt + 1'b1;
               end
            end
            ST_MD_WB: begin
               r_md_wb_en <= 1'b0;
               r_md_busy  <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_md_wb_en <= 1'b0;
               r_md_busy  <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   // Count stalled cycles, holding at the maximum rather than wrapping
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_count <= 16'd0;
      end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
         r_stall_count <= r_stall_count + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_control
//  Description : Self-checking bench for hazard_control. It uses directed
//                scenarios plus a randomized instruction stream. The reference
//                model works from instruction semantics: it builds a list of
//                the registers each instruction reads and follows the
//                mul/div operation as a job that waits some number of cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control;

   localparam int MD_TIMEOUT = 40;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] FD_ir = 32'd0;
   logic [31:0] DX_ir = 32'd0;
   logic        md_result_ready = 1'b0;
   logic        stall_pc, stall_fd, flush_dx, md_start, md_busy, md_wb_en, md_timeout;
   logic [4:0]  md_rd;
   logic [15:0] stall_count;

   hazard_control #(.MD_TIMEOUT(MD_TIMEOUT)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .FD_ir           (FD_ir),
      .DX_ir           (DX_ir),
      .md_result_ready (md_result_ready),
      .stall_pc        (stall_pc),
      .stall_fd        (stall_fd),
      .flush_dx        (flush_dx),
      .md_start        (md_start),
      .md_busy         (md_busy),
      .md_rd           (md_rd),
      .md_wb_en        (md_wb_en),
      .md_timeout      (md_timeout),
      .stall_count     (stall_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit         m_run, m_wb, m_to;
   int         m_wait, m_cnt;
   logic [4:0] m_rd;
   bit         e_stall, e_start;
   logic [27:0] exp_v;
   logic [27:0] obs;
   assign obs = {stall_pc, stall_fd, flush_dx, md_start, md_busy, md_wb_en,
                 md_timeout, md_rd, stall_count};

   // ---------------- instruction helpers ----------------
   function automatic logic [31:0] rtype(logic [4:0] aluop, logic [4:0] rd,
                                         logic [4:0] rs, logic [4:0] rt);
      return {5'd0, rd, rs, rt, 5'd0, aluop, 2'd0};
   endfunction

   function automatic logic [31:0] itype(logic [4:0] op, logic [4:0] rd,
                                         logic [4:0] rs, logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   function automatic bit reads(logic [31:0] ir, logic [4:0] r);
      logic [4:0] srcs[$];
      if (r == 5'd0) return 1'b0;
      case (ir[31:27])
         5'b00000: begin srcs.push_back(ir[21:17]); srcs.push_back(ir[16:12]); end
         5'b00101, 5'b01000: srcs.push_back(ir[21:17]);
         5'b00111, 5'b00010, 5'b00110: begin srcs.push_back(ir[21:17]); srcs.push_back(ir[26:22]); end
         5'b00100: srcs.push_back(ir[26:22]);
         5'b10110: srcs.push_back(5'd30);
         default: ;
      endcase
      foreach (srcs[i]) if (srcs[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit writes(logic [31:0] ir);
      return (ir[31:27] == 5'b00000) || (ir[31:27] == 5'b00101) || (ir[31:27] == 5'b01000);
   endfunction

   function automatic bit is_md(logic [31:0] ir);
      return (ir[31:27] == 5'b00000) && ((ir[6:2] == 5'd6) || (ir[6:2] == 5'd7));
   endfunction

   function automatic logic [4:0] pick_reg(int mode);
      int k = $urandom_range(0, 4);
      if (mode == 0) begin
         case (k) 0: return 5'd0; 1: return 5'd1; 2: return 5'd2; 3: return 5'd3; default: return 5'd30; endcase
      end
      case (k) 0: return 5'd1; 1: return 5'd2; 2: return 5'd4; 3: return 5'd5; default: return 5'd6; endcase
   endfunction

   function automatic logic [31:0] rand_instr(int mode, bit allow_md);
      logic [31:0] ir = $urandom;
      int sel = $urandom_range(0, 11);
      logic [4:0] op;
      case (sel)
         0, 1, 2: op = 5'b00000;
         3: op = 5'b00101;
         4: op = 5'b01000;
         5: op = 5'b00111;
         6: op = 5'b00010;
         7: op = 5'b00110;
         8: op = 5'b00100;
         9: op = 5'b10110;
         10: op = 5'b00011;
         default: op = 5'b10101;
      endcase
      ir[31:27] = op;
      ir[26:22] = pick_reg(mode);
      ir[21:17] = pick_reg(mode);
      ir[16:12] = pick_reg(mode);
      if (op == 5'b00000)
         ir[6:2] = (allow_md && sel == 2) ? 5'(6 + $urandom_range(0, 1)) : 5'($urandom_range(0, 3));
      return ir;
   endfunction

   // ---------------- model ----------------
   task automatic model_reset();
      m_run = 0; m_wb = 0; m_to = 0; m_wait = 0; m_cnt = 0; m_rd = 5'd0;
   endtask

   task automatic model_comb();
      bit ld_use, md_haz;
      ld_use = (DX_ir[31:27] == 5'b01000) && (DX_ir[26:22] != 5'd0) && reads(FD_ir, DX_ir[26:22]);
      md_haz = m_run && (reads(FD_ir, m_rd) ||
                         (writes(FD_ir) && FD_ir[26:22] == m_rd && m_rd != 5'd0) ||
                         is_md(DX_ir));
      e_stall = reset_n && (ld_use || md_haz || m_wb);
      e_start = reset_n && !m_run && !m_wb && is_md(DX_ir);
      exp_v = {e_stall, e_stall, e_stall, e_start, m_run | m_wb, m_wb, m_to, m_rd, 16'(m_cnt)};
   endtask

   task automatic model_edge();
      if (e_stall && m_cnt < 65535) m_cnt++;
      if (m_wb) m_wb = 0;
      else if (m_run) begin
         m_wait++;
         if (md_result_ready) begin m_run = 0; m_wb = 1; end
         else if (m_wait >= MD_TIMEOUT) begin m_run = 0; m_to = 1; m_rd = 5'd0; end
      end else if (e_start) begin
         m_run = 1; m_wait = 0; m_rd = DX_ir[26:22];
      end
   endtask

   task automatic drive(logic [31:0] fd, logic [31:0] dx, logic rdy);
      FD_ir = fd; DX_ir = dx; md_result_ready = rdy;
      #1;
      model_comb();
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset_n = 1'b0; FD_ir = 32'd0; DX_ir = 32'd0; md_result_ready = 1'b0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         FD_ir = rtype(5'd0, 5'd6, 5'd5, 5'd5);
         DX_ir = (i % 2 == 0) ? itype(5'b01000, 5'd5, 5'd1, 17'd4) : rtype(5'd6, 5'd7, 5'd1, 5'd2);
         md_result_ready = 1'b1;
         #1;
         n_checks++;
         if (obs !== 28'd0) begin n_fail++; $display("FAIL reset_state i=%0d: got %h required 0", i, obs); end
      end
      do_reset();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(rtype(5'd0, 5'd6, 5'd5, 5'd2), itype(5'b01000, 5'd5, 5'd1, 17'd8), 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL load_use_model: got %h required %h", obs, exp_v); end
      n_checks++;
      if ({stall_pc, stall_fd, flush_dx} !== 3'b111) begin n_fail++; $display("FAIL load_use_stall: got %b required 111", {stall_pc, stall_fd, flush_dx}); end
      tick();
      drive(rtype(5'd0, 5'd6, 5'd5, 5'd2), 32'd0, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL load_use_bubble_model: got %h required %h", obs, exp_v); end
      n_checks++;
      if (stall_pc !== 1'b0 || stall_count !== 16'd1) begin n_fail++; $display("FAIL load_use_count: stall=%b count=%0d required 0 and 1", stall_pc, stall_count); end
      tick();
   endtask

   task automatic test_load_sources();
      logic [31:0] fds[8];
      logic [31:0] dxs[8];
      logic        exs[8];
      fds = '{rtype(5'd0, 5'd1, 5'd0, 5'd0), itype(5'b00111, 5'd4, 5'd1, 17'd0),
              itype(5'b00100, 5'd9, 5'd0, 17'd0), itype(5'b10110, 5'd0, 5'd0, 17'd5),
              itype(5'b00011, 5'd5, 5'd5, 17'd5), itype(5'b00101, 5'd5, 5'd1, 17'd3),
              rtype(5'd0, 5'd2, 5'd1, 5'd7), itype(5'b01000, 5'd1, 5'd0, 17'd0)};
      dxs = '{itype(5'b01000, 5'd0, 5'd1, 17'd0), itype(5'b01000, 5'd4, 5'd2, 17'd0),
              itype(5'b01000, 5'd9, 5'd2, 17'd0), itype(5'b01000, 5'd30, 5'd2, 17'd0),
              itype(5'b01000, 5'd5, 5'd2, 17'd0), itype(5'b01000, 5'd5, 5'd2, 17'd0),
              itype(5'b01000, 5'd7, 5'd2, 17'd0), itype(5'b01000, 5'd0, 5'd2, 17'd0)};
      exs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(fds[i], dxs[i], 1'b0);
         n_checks++;
         if (stall_pc !== exs[i]) begin n_fail++; $display("FAIL load_src_%0d: stall got %b required %b", i, stall_pc, exs[i]); end
         n_checks++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL load_src_model_%0d: got %h required %h", i, obs, exp_v); end
         tick();
      end
   endtask

   task automatic test_md_dependent();
      logic [31:0] sub_i;
      sub_i = rtype(5'd1, 5'd8, 5'd7, 5'd1);
      do_reset();
      drive(sub_i, rtype(5'd6, 5'd7, 5'd2, 5'd3), 1'b0);
      n_checks++;
      if (obs !== exp_v || md_start !== 1'b1) begin n_fail++; $display("FAIL md_dep_start: got %h required %h", obs, exp_v); end
      tick();
      for (int k = 1; k <= 17; k++) begin
         drive(sub_i, 32'd0, k == 17);
         n_checks++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL md_dep_run_model k=%0d: got %h required %h", k, obs, exp_v); end
         n_checks++;
         if (stall_pc !== 1'b1 || md_start !== 1'b0 || md_rd !== 5'd7 || md_wb_en !== 1'b0) begin
            n_fail++; $display("FAIL md_dep_run k=%0d: stall=%b start=%b rd=%0d wb=%b required 1 0 7 0", k, stall_pc, md_start, md_rd, md_wb_en);
         end
         tick();
      end
      drive(sub_i, 32'd0, 1'b0);
      n_checks++;
      if (obs !== exp_v || md_wb_en !== 1'b1 || stall_pc !== 1'b1) begin n_fail++; $display("FAIL md_dep_wb: got %h required %h", obs, exp_v); end
      tick();
      drive(sub_i, 32'd0, 1'b0);
      n_checks++;
      if (obs !== exp_v || md_busy !== 1'b0 || md_wb_en !== 1'b0 || stall_pc !== 1'b0) begin n_fail++; $display("FAIL md_dep_idle: got %h required %h", obs, exp_v); end
      tick();
   endtask

   task automatic test_md_independent();
      do_reset();
      drive(rand_instr(1, 1'b1), rtype(5'd6, 5'd3, 5'd1, 5'd2), 1'b0);
      n_checks++;
      if (obs !== exp_v || md_start !== 1'b1) begin n_fail++; $display("FAIL md_ind_start: got %h required %h", obs, exp_v); end
      tick();
      for (int k = 1; k <= 10; k++) begin
         drive(rand_instr(1, 1'b1), 32'd0, k == 10);
         n_checks++;
         if (obs !== exp_v || stall_pc !== 1'b0) begin n_fail++; $display("FAIL md_ind_run k=%0d: got %h required %h", k, obs, exp_v); end
         tick();
      end
      drive(rand_instr(1, 1'b1), 32'd0, 1'b0);
      n_checks++;
      if (obs !== exp_v || stall_pc !== 1'b1 || md_wb_en !== 1'b1 || md_rd !== 5'd3) begin n_fail++; $display("FAIL md_ind_wb: got %h required %h", obs, exp_v); end
      tick();
      drive(rand_instr(1, 1'b1), 32'd0, 1'b0);
      n_checks++;
      if (obs !== exp_v || stall_pc !== 1'b0 || md_busy !== 1'b0) begin n_fail++; $display("FAIL md_ind_after: got %h required %h", obs, exp_v); end
      tick();
   endtask

   task automatic test_md_timeout();
      do_reset();
      drive(rand_instr(0, 1'b0), rtype(5'd7, 5'd4, 5'd1, 5'd2), 1'b0);
      n_checks++;
      if (obs !== exp_v || md_start !== 1'b1) begin n_fail++; $display("FAIL md_to_start: got %h required %h", obs, exp_v); end
      tick();
      for (int c = 1; c <= MD_TIMEOUT; c++) begin
         drive(rand_instr(0, 1'b0), 32'd0, 1'b0);
         n_checks++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL md_to_run_model c=%0d: got %h required %h", c, obs, exp_v); end
         n_checks++;
         if (md_busy !== 1'b1 || md_timeout !== 1'b0 || md_wb_en !== 1'b0) begin n_fail++; $display("FAIL md_to_run c=%0d: busy=%b to=%b wb=%b required 1 0 0", c, md_busy, md_timeout, md_wb_en); end
         tick();
      end
      for (int c = 0; c < 6; c++) begin
         drive(rand_instr(0, 1'b0), 32'd0, 1'b1);
         n_checks++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL md_to_after_model c=%0d: got %h required %h", c, obs, exp_v); end
         n_checks++;
         if (md_timeout !== 1'b1 || md_busy !== 1'b0 || md_wb_en !== 1'b0 || md_rd !== 5'd0) begin
            n_fail++; $display("FAIL md_to_after c=%0d: to=%b busy=%b wb=%b rd=%0d required 1 0 0 0", c, md_timeout, md_busy, md_wb_en, md_rd);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] dep;
      dep = rtype(5'd0, 5'd1, 5'd9, 5'd2);
      do_reset();
      drive(dep, rtype(5'd6, 5'd9, 5'd1, 5'd2), 1'b0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL rst_run_start: got %h required %h", obs, exp_v); end
      tick();
      for (int c = 1; c <= 5; c++) begin
         drive(dep, 32'd0, 1'b0);
         n_checks++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL rst_run_model c=%0d: got %h required %h", c, obs, exp_v); end
         if (c < 5) tick();
      end
      n_checks++;
      if (stall_count !== 16'd4 || md_busy !== 1'b1) begin n_fail++; $display("FAIL rst_run_pre: count=%0d busy=%b required 4 1", stall_count, md_busy); end
      reset_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (obs !== 28'd0) begin n_fail++; $display("FAIL rst_run_async: got %h required 0", obs); end
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         drive(rand_instr(0, 1'b0), 32'd0, 1'b1);
         n_checks++;
         if (obs !== exp_v || md_wb_en !== 1'b0) begin n_fail++; $display("FAIL rst_run_after c=%0d: got %h required %h", c, obs, exp_v); end
         tick();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive(rand_instr(0, 1'b1), rand_instr(0, 1'b1), $urandom_range(0, 15) == 0);
         n_checks++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL random i=%0d FD=%h DX=%h: got %h required %h", i, FD_ir, DX_ir, obs, exp_v); end
         tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_use();
      test_load_sources();
      test_md_dependent();
      test_md_independent();
      test_md_timeout();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
